fft_but4_pipe: RTL and testbench

Pipelined, parametrised radix-4 / dual radix-2 FFT butterfly with per-sample mode, selectable scaling with rounding and saturation, optional twiddle multiplication on outputs 1–3, valid/clock-enable flow control, and a sticky overflow flag. It sits between the FFT address/data RAM read path and the write-back path. It supersedes the unregistered-flow, fixed-scale butterfly: a full transform can run without scaling when the data permits, with twiddles applied in the same pass.

---
 rtl/fft_but4_pipe_pkg.sv | 41 ++++
 rtl/fft_but4_pipe_if.sv | 42 ++++
 rtl/fft_cmul_rnd.sv | 68 ++++++
 rtl/fft_but4_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_fft_but4_pipe.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_but4_pipe_pkg.sv
// Shared FFT definitions.
// Purpose: butterfly mode encodings, default sample and twiddle widths,
// and the saturate-and-flag helper used by every rounding stage.
// Ports: none (package).
package fft_but4_pipe_pkg;

  localparam int DEF_BIT    = 17;
  localparam int DEF_TW_BIT = 16;

  // Working width of the saturation helper; every caller sign-extends into it.
  localparam int SAT_W = 64;

  typedef enum logic {
    BUT_R4 = 1'b0,
    BUT_R2 = 1'b1
  } but_mode_e;

  // Clamp v to the signed range of a 'bits'-wide word and report whether
  // the clamp was applied. Callers size-cast the result down to 'bits'.
  function automatic logic signed [SAT_W-1:0] sat_flag(
    input  logic signed [SAT_W-1:0] v,
    input  int                      bits,
    output logic                    clamped
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (bits - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    clamped = 1'b0;
    if (v > hi) begin
      clamped = 1'b1;
      return hi;
    end
    if (v < lo) begin
      clamped = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fft_but4_pipe_if.sv
// Sample-set bus of the radix-4 / dual radix-2 butterfly.
// Purpose: bundles the flow-control, mode, data, twiddle and status signals.
// Signals:
//   ce, valid            pipeline enable and input sample-set valid
//   but_sel, scale, tw_en per-sample mode (radix select, scaling, twiddle)
//   x_re/x_im[4]         input components, BIT wide signed
//   w_re/w_im[3]         twiddles for Y1..Y3, signed Q1.(TW_BIT-1)
//   ovf_clr              clears the sticky overflow flag
//   y_valid, y_re/y_im[4] output sample set
//   ovf                  sticky saturation flag
// Modports: master drives the sample set (upstream / bench), slave is the butterfly.
interface fft_but4_pipe_if #(
  parameter int BIT    = fft_but4_pipe_pkg::DEF_BIT,
  parameter int TW_BIT = fft_but4_pipe_pkg::DEF_TW_BIT
);

  logic                     ce;
  logic                     valid;
  logic                     but_sel;
  logic                     scale;
  logic                     tw_en;
  logic signed [BIT-1:0]    x_re [4];
  logic signed [BIT-1:0]    x_im [4];
  logic signed [TW_BIT-1:0] w_re [3];
  logic signed [TW_BIT-1:0] w_im [3];
  logic                     ovf_clr;
  logic                     y_valid;
  logic signed [BIT-1:0]    y_re [4];
  logic signed [BIT-1:0]    y_im [4];
  logic                     ovf;

  modport master (
    output ce, valid, but_sel, scale, tw_en, x_re, x_im, w_re, w_im, ovf_clr,
    input  y_valid, y_re, y_im, ovf
  );

  modport slave (
    input  ce, valid, but_sel, scale, tw_en, x_re, x_im, w_re, w_im, ovf_clr,
    output y_valid, y_re, y_im, ovf
  );

endinterface

// File: rtl/fft_cmul_rnd.sv
// Registered complex multiply with round and saturate.
// Purpose: output stage for one of Y1..Y3; multiplies by a Q1.(TW_BIT-1)
// twiddle or passes the sample straight through with the same delay.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   ce             stage enable, holds the output register when low
//   en             1 = apply twiddle, 0 = bypass
//   y_re, y_im     sample from the butterfly stage
//   w_re, w_im     twiddle
//   p_re, p_im     registered result
//   clamp          combinational: this cycle's product saturated
module fft_cmul_rnd
  import fft_but4_pipe_pkg::*;
#(
  parameter int BIT    = DEF_BIT,
  parameter int TW_BIT = DEF_TW_BIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     en,
  input  logic signed [BIT-1:0]    y_re,
  input  logic signed [BIT-1:0]    y_im,
  input  logic signed [TW_BIT-1:0] w_re,
  input  logic signed [TW_BIT-1:0] w_im,
  output logic signed [BIT-1:0]    p_re,
  output logic signed [BIT-1:0]    p_im,
  output logic                     clamp
);

  // Full product needs BIT+TW_BIT+1 bits; one more keeps the rounding add exact.
  localparam int EW = BIT + TW_BIT + 2;
  localparam logic signed [EW-1:0] RND = EW'(1) <<< (TW_BIT - 2);

  logic signed [EW-1:0]  prod_re;
  logic signed [EW-1:0]  prod_im;
  logic signed [BIT-1:0] tw_re;
  logic signed [BIT-1:0] tw_im;
  logic signed [BIT-1:0] next_re;
  logic signed [BIT-1:0] next_im;
  logic                  clamp_re;
  logic                  clamp_im;

  // Complex product, round half up, drop the Q fraction bits, then clamp.
  always_comb begin
    prod_re  = EW'(y_re) * EW'(w_re) - EW'(y_im) * EW'(w_im);
    prod_im  = EW'(y_re) * EW'(w_im) + EW'(y_im) * EW'(w_re);
    clamp_re = 1'b0;
    clamp_im = 1'b0;
    tw_re    = BIT'(sat_flag(SAT_W'((prod_re + RND) >>> (TW_BIT - 1)), BIT, clamp_re));
    tw_im    = BIT'(sat_flag(SAT_W'((prod_im + RND) >>> (TW_BIT - 1)), BIT, clamp_im));
    clamp    = en & (clamp_re | clamp_im);
    next_re  = en ? tw_re : y_re;
    next_im  = en ? tw_im : y_im;
  end

  // Output register of the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_re <= '0;
      p_im <= '0;
    end else if (ce) begin
      p_re <= next_re;
      p_im <= next_im;
    end
  end

endmodule

// File: rtl/fft_but4_pipe.sv
// Pipelined radix-4 / dual radix-2 FFT butterfly.
// Purpose: S1 input register, S2 butterfly + scale/round + saturate,
// S3 optional twiddle multiply on Y1..Y3, with per-sample mode, valid
// pipeline gated by ce, and a sticky overflow flag.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset, overrides ce
//   bus   fft_but4_pipe_if.slave sample-set bus
module fft_but4_pipe
  import fft_but4_pipe_pkg::*;
#(
  parameter int BIT    = DEF_BIT,
  parameter int TW_BIT = DEF_TW_BIT
) (
  input logic           clk,
  input logic           rst,
  fft_but4_pipe_if.slave bus
);

  // Butterfly sums need BIT+2 bits; one more absorbs the rounding term.
  localparam int SW = BIT + 3;

  logic                     s1_valid;
  but_mode_e                s1_mode;
  logic                     s1_scale;
  logic                     s1_tw_en;
  logic signed [BIT-1:0]    s1_x_re [4];
  logic signed [BIT-1:0]    s1_x_im [4];
  logic signed [TW_BIT-1:0] s1_w_re [3];
  logic signed [TW_BIT-1:0] s1_w_im [3];

  logic signed [SW-1:0]     a_re [4];
  logic signed [SW-1:0]     a_im [4];
  logic signed [SW-1:0]     sum_re [4];
  logic signed [SW-1:0]     sum_im [4];
  logic [1:0]               shift;
  logic signed [SW-1:0]     rnd;
  logic signed [BIT-1:0]    bf_re [4];
  logic signed [BIT-1:0]    bf_im [4];
  logic                     bf_clamp;
  logic                     c_re;
  logic                     c_im;

  logic                     s2_valid;
  logic                     s2_tw_en;
  logic                     s2_clamp;
  logic signed [BIT-1:0]    s2_y_re [4];
  logic signed [BIT-1:0]    s2_y_im [4];
  logic signed [TW_BIT-1:0] s2_w_re [3];
  logic signed [TW_BIT-1:0] s2_w_im [3];

  logic signed [BIT-1:0]    y0_re;
  logic signed [BIT-1:0]    y0_im;
  logic signed [BIT-1:0]    cm_re [1:3];
  logic signed [BIT-1:0]    cm_im [1:3];
  logic [3:1]               tw_clamp;
  logic                     out_valid;
  logic                     ovf_q;

  // S1: capture the sample set together with its mode and twiddles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= BUT_R4;
      s1_scale <= 1'b0;
      s1_tw_en <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s1_x_re[k] <= '0;
        s1_x_im[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        s1_w_re[k] <= '0;
        s1_w_im[k] <= '0;
      end
    end else if (bus.ce) begin
      s1_valid <= bus.valid;
      s1_mode  <= but_mode_e'(bus.but_sel);
      s1_scale <= bus.scale;
      s1_tw_en <= bus.tw_en;
      for (int k = 0; k < 4; k++) begin
        s1_x_re[k] <= bus.x_re[k];
        s1_x_im[k] <= bus.x_im[k];
      end
      for (int k = 0; k < 3; k++) begin
        s1_w_re[k] <= bus.w_re[k];
        s1_w_im[k] <= bus.w_im[k];
      end
    end
  end

  // Butterfly adders at full width; the -j rotation is a re/im swap with sign.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a_re[k] = SW'(s1_x_re[k]);
      a_im[k] = SW'(s1_x_im[k]);
    end
    if (s1_mode == BUT_R4) begin
      sum_re[0] = a_re[0] + a_re[1] + a_re[2] + a_re[3];
      sum_im[0] = a_im[0] + a_im[1] + a_im[2] + a_im[3];
      sum_re[1] = a_re[0] + a_im[1] - a_re[2] - a_im[3];
      sum_im[1] = a_im[0] - a_re[1] - a_im[2] + a_re[3];
      sum_re[2] = a_re[0] - a_re[1] + a_re[2] - a_re[3];
      sum_im[2] = a_im[0] - a_im[1] + a_im[2] - a_im[3];
      sum_re[3] = a_re[0] - a_im[1] - a_re[2] + a_im[3];
      sum_im[3] = a_im[0] + a_re[1] - a_im[2] - a_re[3];
      shift     = s1_scale ? 2'd2 : 2'd0;
    end else begin
      sum_re[0] = a_re[0] + a_re[1];
      sum_im[0] = a_im[0] + a_im[1];
      sum_re[1] = a_re[0] - a_re[1];
      sum_im[1] = a_im[0] - a_im[1];
      sum_re[2] = a_re[2] + a_re[3];
      sum_im[2] = a_im[2] + a_im[3];
      sum_re[3] = a_re[2] - a_re[3];
      sum_im[3] = a_im[2] - a_im[3];
      shift     = s1_scale ? 2'd1 : 2'd0;
    end
  end

  // Scale with round-half-up, then clamp. For shifts 0/1/2 the rounding
  // constant 2^(s-1) (or 0) equals the shift amount itself.
  always_comb begin
    rnd      = SW'(shift);
    bf_clamp = 1'b0;
    c_re     = 1'b0;
    c_im     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bf_re[k] = BIT'(sat_flag(SAT_W'((sum_re[k] + rnd) >>> shift), BIT, c_re));
      bf_im[k] = BIT'(sat_flag(SAT_W'((sum_im[k] + rnd) >>> shift), BIT, c_im));
      bf_clamp = bf_clamp | c_re | c_im;
    end
  end

  // S2: butterfly result, its clamp status and the twiddles it still needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_tw_en <= 1'b0;
      s2_clamp <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s2_y_re[k] <= '0;
        s2_y_im[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        s2_w_re[k] <= '0;
        s2_w_im[k] <= '0;
      end
    end else if (bus.ce) begin
      s2_valid <= s1_valid;
      s2_tw_en <= s1_tw_en;
      s2_clamp <= bf_clamp;
      for (int k = 0; k < 4; k++) begin
        s2_y_re[k] <= bf_re[k];
        s2_y_im[k] <= bf_im[k];
      end
      for (int k = 0; k < 3; k++) begin
        s2_w_re[k] <= s2_w_re[k];
        s2_w_im[k] <= s2_w_im[k];
        s2_w_re[k] <= s1_w_re[k];
        s2_w_im[k] <= s1_w_im[k];
      end
    end
  end

  // S3: Y1..Y3 through the twiddle multipliers.
  for (genvar k = 1; k < 4; k++) begin : g_tw
    fft_cmul_rnd #(
      .BIT    (BIT),
      .TW_BIT (TW_BIT)
    ) u_cmul (
      .clk   (clk),
      .rst   (rst),
      .ce    (bus.ce),
      .en    (s2_tw_en),
      .y_re  (s2_y_re[k]),
      .y_im  (s2_y_im[k]),
      .w_re  (s2_w_re[k-1]),
      .w_im  (s2_w_im[k-1]),
      .p_re  (cm_re[k]),
      .p_im  (cm_im[k]),
      .clamp (tw_clamp[k])
    );
  end

  // S3: Y0 is never rotated, it only needs the matching delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      y0_re     <= '0;
      y0_im     <= '0;
      out_valid <= 1'b0;
    end else if (bus.ce) begin
      y0_re     <= s2_y_re[0];
      y0_im     <= s2_y_im[0];
      out_valid <= s2_valid;
    end
  end

  // Sticky overflow: raised when a valid set leaving S2 clamped anywhere;
  // a set wins over a clear in the same cycle, and clear works while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.ce && s2_valid && (s2_clamp || (|tw_clamp))) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    bus.y_valid = out_valid;
    bus.ovf     = ovf_q;
    bus.y_re[0] = y0_re;
    bus.y_im[0] = y0_im;
    for (int k = 1; k < 4; k++) begin
      bus.y_re[k] = cm_re[k];
      bus.y_im[k] = cm_im[k];
    end
  end

endmodule

// File: tb/tb_fft_but4_pipe.sv
// Self-checking bench for fft_but4_pipe.
// Purpose: directed test-plan scenarios followed by a randomized run, each
// cycle checked against an arithmetic reference model of the butterfly.
// Ports: none (top-level bench).
module tb_fft_but4_pipe;
  import fft_but4_pipe_pkg::*;

  localparam int     BIT    = 17;
  localparam int     TW_BIT = 16;
  localparam longint YMAX   = 65535;
  localparam longint YMIN   = -65536;

  typedef struct packed {
    logic                 valid;
    logic                 clamp;
    logic [7:0][BIT-1:0]  y;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t pipe [3];
  logic exp_ovf = 1'b0;
  int   vectors = 0;
  int   checks = 0;
  int   miscompares = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  fft_but4_pipe_if #(.BIT(BIT), .TW_BIT(TW_BIT)) bus ();

  fft_but4_pipe #(.BIT(BIT), .TW_BIT(TW_BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic longint floor_div(input longint num, input longint d);
    longint q;
    q = num / d;
    if ((num % d != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint v, output logic c);
    c = 1'b0;
    if (v > YMAX) begin c = 1'b1; return YMAX; end
    if (v < YMIN) begin c = 1'b1; return YMIN; end
    return v;
  endfunction

  // Expected output for the sample set currently on the bus.
  function automatic exp_t model();
    longint xr [4];
    longint xi [4];
    longint sr [4];
    longint si [4];
    longint yr, yi, wr, wi, pr, pim;
    longint sdiv;
    logic   c1, c2;
    exp_t   e;
    e       = '0;
    e.valid = bus.valid;
    for (int k = 0; k < 4; k++) begin
      xr[k] = longint'(bus.x_re[k]);
      xi[k] = longint'(bus.x_im[k]);
    end
    if (bus.but_sel == 1'b0) begin
      sr[0] = xr[0] + xr[1] + xr[2] + xr[3];  si[0] = xi[0] + xi[1] + xi[2] + xi[3];
      sr[1] = xr[0] + xi[1] - xr[2] - xi[3];  si[1] = xi[0] - xr[1] - xi[2] + xr[3];
      sr[2] = xr[0] - xr[1] + xr[2] - xr[3];  si[2] = xi[0] - xi[1] + xi[2] - xi[3];
      sr[3] = xr[0] - xi[1] - xr[2] + xi[3];  si[3] = xi[0] + xr[1] - xi[2] - xr[3];
      sdiv  = bus.scale ? 4 : 1;
    end else begin
      sr[0] = xr[0] + xr[1];  si[0] = xi[0] + xi[1];
      sr[1] = xr[0] - xr[1];  si[1] = xi[0] - xi[1];
      sr[2] = xr[2] + xr[3];  si[2] = xi[2] + xi[3];
      sr[3] = xr[2] - xr[3];  si[3] = xi[2] - xi[3];
      sdiv  = bus.scale ? 2 : 1;
    end
    for (int k = 0; k < 4; k++) begin
      yr = clampv(floor_div(sr[k] + sdiv / 2, sdiv), c1);
      yi = clampv(floor_div(si[k] + sdiv / 2, sdiv), c2);
      e.clamp = e.clamp | c1 | c2;
      if (k > 0 && bus.tw_en) begin
        wr  = longint'(bus.w_re[k-1]);
        wi  = longint'(bus.w_im[k-1]);
        pr  = yr * wr - yi * wi;
        pim = yr * wi + yi * wr;
        yr  = clampv(floor_div(pr + 16384, 32768), c1);
        yi  = clampv(floor_div(pim + 16384, 32768), c2);
        e.clamp = e.clamp | c1 | c2;
      end
      e.y[2*k]   = yr[BIT-1:0];
      e.y[2*k+1] = yi[BIT-1:0];
    end
    return e;
  endfunction

  task automatic checkOutput();
    logic [7:0][BIT-1:0] act;
    for (int k = 0; k < 4; k++) begin
      act[2*k]   = bus.y_re[k];
      act[2*k+1] = bus.y_im[k];
    end
    checks += 3;
    assert (bus.y_valid === pipe[2].valid) else begin
      miscompares++;
      $error("[TB] FAIL y_valid t=%0t observed %b expected %b", $time, bus.y_valid, pipe[2].valid);
    end
    assert (bus.ovf === exp_ovf) else begin
      miscompares++;
      $error("[TB] FAIL ovf t=%0t observed %b expected %b", $time, bus.ovf, exp_ovf);
    end
    assert (act === pipe[2].y) else begin
      miscompares++;
      $error("[TB] FAIL y t=%0t observed %h expected %h", $time, act, pipe[2].y);
    end
  endtask

  // One clock: drive controls, advance the reference, check after the edge.
  task automatic applyStimulus(input logic ce_v, input logic valid_v, input logic clr_v);
    exp_t e;
    bus.ce      = ce_v;
    bus.valid   = valid_v;
    bus.ovf_clr = clr_v;
    e = model();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      exp_ovf = 1'b0;
    end else if (ce_v) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
      if (pipe[2].valid && pipe[2].clamp) exp_ovf = 1'b1;
      else if (clr_v) exp_ovf = 1'b0;
    end else if (clr_v) begin
      exp_ovf = 1'b0;
    end
    vectors++;
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_mode(input logic bs, input logic sc, input logic tw);
    bus.but_sel = bs;
    bus.scale   = sc;
    bus.tw_en   = tw;
  endtask

  task automatic set_x(input int k, input int re, input int im);
    bus.x_re[k] = BIT'(re);
    bus.x_im[k] = BIT'(im);
  endtask

  task automatic set_w(input int k, input int re, input int im);
    bus.w_re[k] = TW_BIT'(re);
    bus.w_im[k] = TW_BIT'(im);
  endtask

  task automatic clear_data();
    for (int k = 0; k < 4; k++) set_x(k, 0, 0);
    for (int k = 0; k < 3; k++) set_w(k, 0, 0);
  endtask

  task automatic rand_data(input logic wide);
    for (int k = 0; k < 4; k++) begin
      if (wide) begin
        bus.x_re[k] = BIT'($urandom);
        bus.x_im[k] = BIT'($urandom);
      end else begin
        bus.x_re[k] = BIT'($signed(13'($urandom)));
        bus.x_im[k] = BIT'($signed(13'($urandom)));
      end
    end
    for (int k = 0; k < 3; k++) begin
      bus.w_re[k] = TW_BIT'($urandom);
      bus.w_im[k] = TW_BIT'($urandom);
    end
  endtask

  // Bound on total run time.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    set_mode(BUT_R4, 1'b0, 1'b0);
    clear_data();
    bus.ce = 1'b0;
    bus.valid = 1'b0;
    bus.ovf_clr = 1'b0;

    $display("[TB] reset");
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("[TB] radix-4 scaled, all x=(1000,0)");
    set_mode(BUT_R4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) set_x(k, 1000, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clear_data();
    idle(3);

    $display("[TB] rounding");
    set_x(0, 2, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    set_x(0, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    set_x(0, -2, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clear_data();
    idle(3);

    $display("[TB] saturation and sticky overflow");
    set_mode(BUT_R4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) set_x(k, 65535, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clear_data();
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) set_x(k, 65535, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clear_data();
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);

    $display("[TB] twiddle");
    set_mode(BUT_R2, 1'b0, 1'b1);
    set_x(0, 100, 0);
    set_w(0, 0, -32768);
    applyStimulus(1'b1, 1'b1, 1'b0);
    set_x(0, -65536, 0);
    set_w(0, -32768, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    clear_data();
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b1);

    $display("[TB] flow with stall");
    for (int i = 0; i < 8; i++) begin
      set_mode(1'(i % 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rand_data(1'b0);
      if (i == 4) begin
        applyStimulus(1'b0, 1'b1, 1'b0);
        rand_data(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        rand_data(1'b0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b1);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) begin
      rand_data(1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    idle(2);
    set_mode(BUT_R4, 1'b1, 1'b1);
    rand_data(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(3);

    $display("[TB] randomized run");
    for (int i = 0; i < 300; i++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rand_data(1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 63) == 0);
      applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) == 0));
      rst = 1'b0;
    end

    $display("[TB] %0d comparisons made", checks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
